sext_addr_sequencer: RTL and testbench
======================================

Name: sext_addr_sequencer

Overview:
- Multi-cycle controller that sequences the LC-3 immediate/offset sign-extension and address-add datapath for one instruction at a time.
- Accepts IR and incremented PC over a valid/ready handshake.
- Decodes which field to sign-extend (imm5, offset6, PCoffset9, PCoffset11, trapvect8) and selects the base: none, PC, or BaseR via a register-file read request.
- Returns the effective address or operand over a second valid/ready handshake. Sits between the fetch/decode stage and the MAR/ALU operand muxes.

Parameters:
- RF_TIMEOUT, 15: maximum number of RDREG cycles spent waiting for rf_ack before aborting. Legal range 1..255.

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-low reset
- in_valid  in  1  IR/PC presented
- in_ready  out  1  sequencer can accept
- ir  in  16  instruction word
- pc  in  16  already-incremented PC
- rf_req  out  1  register-file read request
- rf_sr  out  3  register to read (ir[8:6])
- rf_ack  in  1  rf_data valid this cycle
- rf_data  in  16  register contents
- ea_valid  out  1  result valid
- ea_ready  in  1  consumer accepts result
- ea  out  16  effective address / operand
- ea_kind  out  2  0 OPERAND, 1 ADDRESS, 2 NONE, 3 TIMEOUT

Behaviour:
- Reset: while Reset=0 at an edge, state becomes IDLE. Resulting values: in_ready=0 while Reset low, rf_req=0, ea_valid=0, ea=0, ea_kind=0, timeout counter=0. Reset overrides all other events, including mid-RDREG or mid-HOLD; an in-flight instruction is dropped.
- States: IDLE, DECODE, RDREG, ADD, HOLD.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready at an edge latches ir and pc, then goes to DECODE.
- DECODE (opcode = ir[15:12]):
  - ADD/AND (0001/0101) with ir[5]=1: OPERAND, value = sext(ir[4:0]), go to ADD.
  - ADD/AND with ir[5]=0, NOT (1001), RTI (1000), reserved (1101): NONE, ea=0, go to HOLD.
  - BR/LD/ST/LDI/STI/LEA (0000/0010/0011/1010/1011/1110): ADDRESS, pc + sext(ir[8:0]), go to ADD.
  - JSR (0100) with ir[11]=1: ADDRESS, pc + sext(ir[10:0]), go to ADD.
  - LDR/STR (0110/0111): ADDRESS, BaseR + sext(ir[5:0]), go to RDREG.
  - JMP (1100), or JSR with ir[11]=0: ADDRESS, BaseR + 0, go to RDREG.
  - TRAP (1111): ADDRESS, ea = {8'h00, ir[7:0]} (zero-extended), go to ADD.
- RDREG:
  - rf_req=1 and rf_sr=ir[8:6], both held stable for the whole state.
  - rf_ack latches rf_data as base and goes to ADD.
  - Otherwise the counter increments. After RF_TIMEOUT RDREG cycles with no ack, go to HOLD with ea_kind=3 and ea=0.
  - An ack in the last allowed cycle wins over timeout.
  - The counter clears on RDREG entry.
- ADD:
  - ea = (base + offset) mod 2^16; wrap-around is silent.
  - OPERAND and TRAP pass their value with no add.
  - Go to HOLD.
- HOLD:
  - ea_valid=1.
  - ea and ea_kind stay stable while ea_ready=0.
  - ea_ready at an edge goes to IDLE.
  - in_ready=0; there is no overlap of instructions.
- Latency from the accept edge: PC-relative or immediate gives ea_valid in the 3rd cycle after accept. BaseR gives ea_valid 2 cycles after the cycle in which rf_ack was sampled high.
- rf_ack outside RDREG is ignored.

Optional Feature:
- Macro: SEXT_SEQ_STATS_EN.
- Defined:
  - Adds output port op_count [15:0].
  - op_count increments on every ea_valid&ea_ready handshake and saturates at 16'hFFFF.
  - A separate 8-bit output timeout_count counts kind-3 results and saturates at 8'hFF.
  - Both counters clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- ADD imm: ir=16'h1030 → ea=16'hFFF0, kind 0, ea_valid 3 cycles after accept, no rf_req.
- LD: pc=16'h3001, ir=16'h21FF → ea=16'h3000, kind 1.
- JSR with wrap: pc=16'h0100, ir=16'h4C00 → ea=16'hFD00, kind 1.
- LDR: ir=16'h60BE, rf_sr must equal 2, rf_ack after 4 cycles with rf_data=16'h3000 → ea=16'h2FFE, kind 1, ea_valid 2 cycles after ack.
- JMP R7 timeout: ir=16'hC1C0, rf_ack never asserted, RF_TIMEOUT=15 → exactly 15 cycles of rf_req, then kind 3, ea=0. Repeat with ack on the 15th cycle and rf_data=16'h1234 → ea=16'h1234, kind 1.
- Backpressure then reset: hold ea_ready=0 for 5 cycles → ea/ea_kind stable. Then start an LDR and drive Reset=0 mid-RDREG → next cycle rf_req=0, ea_valid=0. After release, in_ready=1 and a new ir=16'h0000 gives ea=pc, kind 1.

Source files
------------

// File: rtl/sext_addr_sequencer.sv
// LC-3 offset sign-extension / address-add sequencer: one instruction at a time, IR+PC in, EA out.
// Optional SEXT_SEQ_STATS_EN adds op_count and timeout_count result counters.
module sext_addr_sequencer #(
    parameter int RF_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] ir,
    input  logic [15:0] pc,
    output logic        rf_req,
    output logic [2:0]  rf_sr,
    input  logic        rf_ack,
    input  logic [15:0] rf_data,
    output logic        ea_valid,
    input  logic        ea_ready,
    output logic [15:0] ea,
    output logic [1:0]  ea_kind
`ifdef SEXT_SEQ_STATS_EN
    ,
    output logic [15:0] op_count,
    output logic [7:0]  timeout_count
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_RDREG, S_ADD, S_HOLD} state_t;

    localparam logic [1:0] K_OPERAND = 2'd0;
    localparam logic [1:0] K_ADDRESS = 2'd1;
    localparam logic [1:0] K_NONE    = 2'd2;
    localparam logic [1:0] K_TIMEOUT = 2'd3;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;
    logic [15:0] r_pc;
    logic [15:0] r_base;
    logic [15:0] r_off;
    logic [1:0]  r_kind;
    logic [7:0]  r_cnt;
    logic [15:0] r_ea;
    logic [1:0]  r_ea_kind;

    logic [3:0]  w_op;
    logic [1:0]  w_dec_kind;
    logic [15:0] w_dec_off;
    logic [15:0] w_dec_base;
    state_t      w_dec_next;
    logic        w_cnt_last;

    assign w_op       = r_ir[15:12];
    assign w_cnt_last = (r_cnt == 8'(RF_TIMEOUT - 1));

    // Operand and TRAP values ride through ADD with a zero base.
    always_comb begin
        w_dec_kind = K_ADDRESS;
        w_dec_off  = 16'h0000;
        w_dec_base = 16'h0000;
        w_dec_next = S_HOLD;
        case (w_op)
            4'b0001, 4'b0101: begin
                if (r_ir[5]) begin
                    w_dec_kind = K_OPERAND;
                    w_dec_off  = {{11{r_ir[4]}}, r_ir[4:0]};
                    w_dec_next = S_ADD;
                end else begin
                    w_dec_kind = K_NONE;
                end
            end
            4'b0000, 4'b0010, 4'b0011, 4'b1010, 4'b1011, 4'b1110: begin
                w_dec_off  = {{7{r_ir[8]}}, r_ir[8:0]};
                w_dec_base = r_pc;
                w_dec_next = S_ADD;
            end
            4'b0100: begin
                if (r_ir[11]) begin
                    w_dec_off  = {{5{r_ir[10]}}, r_ir[10:0]};
                    w_dec_base = r_pc;
                    w_dec_next = S_ADD;
                end else begin
                    w_dec_next = S_RDREG;
                end
            end
            4'b0110, 4'b0111: begin
                w_dec_off  = {{10{r_ir[5]}}, r_ir[5:0]};
                w_dec_next = S_RDREG;
            end
            4'b1100: w_dec_next = S_RDREG;
            4'b1111: begin
                w_dec_off  = {8'h00, r_ir[7:0]};
                w_dec_next = S_ADD;
            end
            default: w_dec_kind = K_NONE;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next = S_DECODE;
            S_DECODE: w_next = w_dec_next;
            S_RDREG: begin
                if (rf_ack)          w_next = S_ADD;
                else if (w_cnt_last) w_next = S_HOLD;
            end
            S_ADD:    w_next = S_HOLD;
            S_HOLD:   if (ea_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_ir      <= 16'h0000;
            r_pc      <= 16'h0000;
            r_base    <= 16'h0000;
            r_off     <= 16'h0000;
            r_kind    <= K_OPERAND;
            r_cnt     <= 8'h00;
            r_ea      <= 16'h0000;
            r_ea_kind <= K_OPERAND;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_ir <= ir;
                        r_pc <= pc;
                    end
                end
                S_DECODE: begin
                    r_kind <= w_dec_kind;
                    r_off  <= w_dec_off;
                    r_base <= w_dec_base;
                    r_cnt  <= 8'h00;
                    if (w_dec_next == S_HOLD) begin
                        r_ea      <= 16'h0000;
                        r_ea_kind <= w_dec_kind;
                    end
                end
                S_RDREG: begin
                    // An ack on the final allowed cycle beats the timeout.
                    if (rf_ack) begin
                        r_base <= rf_data;
                    end else if (w_cnt_last) begin
                        r_ea      <= 16'h0000;
                        r_ea_kind <= K_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 8'h01;
                    end
                end
                S_ADD: begin
                    r_ea      <= r_base + r_off;
                    r_ea_kind <= r_kind;
                end
                default: ;
            endcase
        end
    end

`ifdef SEXT_SEQ_STATS_EN
    logic [15:0] r_op_count;
    logic [7:0]  r_timeout_count;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_op_count      <= 16'h0000;
            r_timeout_count <= 8'h00;
        end else if (r_state == S_HOLD && ea_ready) begin
            if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'h0001;
            if (r_ea_kind == K_TIMEOUT && r_timeout_count != 8'hFF)
                r_timeout_count <= r_timeout_count + 8'h01;
        end
    end

    assign op_count      = r_op_count;
    assign timeout_count = r_timeout_count;
`endif

    assign in_ready = Reset && (r_state == S_IDLE);
    assign rf_req   = (r_state == S_RDREG);
    assign rf_sr    = r_ir[8:6];
    assign ea_valid = (r_state == S_HOLD);
    assign ea       = r_ea;
    assign ea_kind  = r_ea_kind;

endmodule

// File: tb/tb_sext_addr_sequencer.sv
// Directed bench for sext_addr_sequencer: decode kinds, latency, register-read timeout, backpressure and reset.
module tb_sext_addr_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] ir = 16'h0000;
    logic [15:0] pc = 16'h0000;
    logic        rf_req;
    logic [2:0]  rf_sr;
    logic        rf_ack = 1'b0;
    logic [15:0] rf_data = 16'h0000;
    logic        ea_valid;
    logic        ea_ready = 1'b0;
    logic [15:0] ea;
    logic [1:0]  ea_kind;
`ifdef SEXT_SEQ_STATS_EN
    logic [15:0] op_count;
    logic [7:0]  timeout_count;
`endif

    int n_pass = 0;
    int n_total = 0;

    sext_addr_sequencer #(.RF_TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .ir(ir), .pc(pc), .rf_req(rf_req), .rf_sr(rf_sr), .rf_ack(rf_ack),
        .rf_data(rf_data), .ea_valid(ea_valid), .ea_ready(ea_ready),
        .ea(ea), .ea_kind(ea_kind)
`ifdef SEXT_SEQ_STATS_EN
        , .op_count(op_count), .timeout_count(timeout_count)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic issue(input logic [15:0] i_ir, input logic [15:0] i_pc);
        @(negedge Clk);
        in_valid = 1'b1;
        ir = i_ir;
        pc = i_pc;
        @(posedge Clk);
        #1 in_valid = 1'b0;
    endtask

    // Negedges after the accept edge until ea_valid (0 = never), counting rf_req cycles.
    task automatic wait_ea(output int cyc, output int nreq);
        cyc = 0;
        nreq = 0;
        for (int t = 1; t <= 60; t++) begin
            @(negedge Clk);
            if (rf_req) nreq++;
            if (ea_valid) begin
                cyc = t;
                break;
            end
        end
    endtask

    // Register-read instruction; ack pulsed in the ack_at-th rf_req cycle (0 = never).
    task automatic run_rdreg(input logic [15:0] i_ir, input int ack_at, input logic [15:0] data,
                             input logic [2:0] exp_sr, output int nreq, output int after_ack,
                             output int sr_bad);
        int t_ack;
        int t_val;
        t_ack = 0;
        t_val = 0;
        nreq = 0;
        sr_bad = 0;
        issue(i_ir, 16'h0000);
        for (int t = 1; t <= 60; t++) begin
            @(negedge Clk);
            rf_ack = 1'b0;
            if (ea_valid) begin
                t_val = t;
                break;
            end
            if (rf_req) begin
                nreq++;
                if (rf_sr !== exp_sr) sr_bad++;
                if (nreq == ack_at) begin
                    rf_ack = 1'b1;
                    rf_data = data;
                    t_ack = t;
                end
            end
        end
        rf_ack = 1'b0;
        after_ack = (t_val == 0) ? -1 : t_val - t_ack;
    endtask

    task automatic retire;
        @(negedge Clk);
        ea_ready = 1'b1;
        @(posedge Clk);
        #1 ea_ready = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_total++;
        if ({in_ready, rf_req, ea_valid} !== 3'b000)
            $display("FAIL reset_ctrl got %b want 000", {in_ready, rf_req, ea_valid});
        else n_pass++;
        n_total++;
        if ({ea, ea_kind} !== 18'h0)
            $display("FAIL reset_ea got ea=%h kind=%0d want 0/0", ea, ea_kind);
        else n_pass++;
        Reset = 1'b1;
        @(negedge Clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release in_ready got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_add_imm;
        int cyc, nreq;
        issue(16'h1030, 16'h0000);
        wait_ea(cyc, nreq);
        n_total++;
        if (cyc !== 3) $display("FAIL add_imm latency got %0d want 3", cyc);
        else n_pass++;
        n_total++;
        if (nreq !== 0) $display("FAIL add_imm rf_req cycles got %0d want 0", nreq);
        else n_pass++;
        n_total++;
        if (ea !== 16'hFFF0 || ea_kind !== 2'd0)
            $display("FAIL add_imm got ea=%h kind=%0d want fff0/0", ea, ea_kind);
        else n_pass++;
        retire();
    endtask

    task automatic test_pc_rel(input string name, input logic [15:0] i_ir, input logic [15:0] i_pc,
                               input logic [15:0] exp_ea, input logic [1:0] exp_kind);
        int cyc, nreq;
        issue(i_ir, i_pc);
        wait_ea(cyc, nreq);
        n_total++;
        if (cyc !== 3 || ea !== exp_ea || ea_kind !== exp_kind)
            $display("FAIL %s got lat=%0d ea=%h kind=%0d want 3/%h/%0d",
                     name, cyc, ea, ea_kind, exp_ea, exp_kind);
        else n_pass++;
        retire();
    endtask

    task automatic test_ldr;
        int nreq, aft, srb;
        run_rdreg(16'h60BE, 4, 16'h3000, 3'd2, nreq, aft, srb);
        n_total++;
        if (nreq !== 4 || srb !== 0)
            $display("FAIL ldr rf_req got %0d cycles/%0d bad sr want 4/0", nreq, srb);
        else n_pass++;
        n_total++;
        if (aft !== 2) $display("FAIL ldr ack_to_valid got %0d want 2", aft);
        else n_pass++;
        n_total++;
        if (ea !== 16'h2FFE || ea_kind !== 2'd1)
            $display("FAIL ldr got ea=%h kind=%0d want 2ffe/1", ea, ea_kind);
        else n_pass++;
        retire();
    endtask

    task automatic test_jmp_timeout;
        int nreq, aft, srb;
        run_rdreg(16'hC1C0, 0, 16'h0000, 3'd7, nreq, aft, srb);
        n_total++;
        if (nreq !== 15 || srb !== 0)
            $display("FAIL jmp_timeout rf_req got %0d cycles/%0d bad sr want 15/0", nreq, srb);
        else n_pass++;
        n_total++;
        if (ea !== 16'h0000 || ea_kind !== 2'd3)
            $display("FAIL jmp_timeout got ea=%h kind=%0d want 0000/3", ea, ea_kind);
        else n_pass++;
        retire();
        run_rdreg(16'hC1C0, 15, 16'h1234, 3'd7, nreq, aft, srb);
        n_total++;
        if (nreq !== 15 || aft !== 2 || ea !== 16'h1234 || ea_kind !== 2'd1)
            $display("FAIL jmp_ack_last got req=%0d aft=%0d ea=%h kind=%0d want 15/2/1234/1",
                     nreq, aft, ea, ea_kind);
        else n_pass++;
        retire();
    endtask

    task automatic test_backpressure_reset;
        int cyc, nreq, unstable;
        unstable = 0;
        issue(16'h21FF, 16'h3001);
        wait_ea(cyc, nreq);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (ea_valid !== 1'b1 || ea !== 16'h3000 || ea_kind !== 2'd1 || in_ready !== 1'b0)
                unstable++;
        end
        n_total++;
        if (unstable !== 0) $display("FAIL hold_stable got %0d bad cycles want 0", unstable);
        else n_pass++;
        retire();
        issue(16'h60BE, 16'h0000);
        for (int t = 0; t < 10 && !rf_req; t++) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        n_total++;
        if ({rf_req, ea_valid, in_ready} !== 3'b000)
            $display("FAIL mid_rdreg_reset got %b want 000", {rf_req, ea_valid, in_ready});
        else n_pass++;
        Reset = 1'b1;
        @(negedge Clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL post_reset in_ready got %b want 1", in_ready);
        else n_pass++;
        test_pc_rel("br_after_reset", 16'h0000, 16'h4567, 16'h4567, 2'd1);
`ifdef SEXT_SEQ_STATS_EN
        n_total++;
        if (op_count !== 16'd1 || timeout_count !== 8'd0)
            $display("FAIL stats got op=%0d to=%0d want 1/0", op_count, timeout_count);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_pc_rel("ld", 16'h21FF, 16'h3001, 16'h3000, 2'd1);
        test_pc_rel("jsr_wrap", 16'h4C00, 16'h0100, 16'hFD00, 2'd1);
        test_pc_rel("trap", 16'hF025, 16'h8000, 16'h0025, 2'd1);
        test_ldr();
        test_jmp_timeout();
        test_backpressure_reset();
        // NONE kinds skip ADD, so they surface one cycle earlier.
        begin
            int cyc, nreq;
            issue(16'h903F, 16'h1111);
            wait_ea(cyc, nreq);
            n_total++;
            if (cyc !== 2 || ea !== 16'h0000 || ea_kind !== 2'd2)
                $display("FAIL not_none got lat=%0d ea=%h kind=%0d want 2/0000/2", cyc, ea, ea_kind);
            else n_pass++;
            retire();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
